// File: rtl/char_motion_fsm.sv
// Jump-game character engine: walks, charges and launches a sprite inside a walled arena.
// Every register advances only on physics ticks; sys_rst forces the spawn pose at any edge.
module char_motion_fsm #(
    parameter int PHY_WIDTH    = 10,
    parameter int MAP_X_OFFSET = 270,
    parameter int MAP_Y_OFFSET = 50,
    parameter int MAP_WIDTH_X  = 100,
    parameter int MAP_WIDTH_Y  = 100,
    parameter int WALL_WIDTH   = 10,
    parameter int CHAR_WIDTH_X = 32,
    parameter int CHAR_WIDTH_Y = 32,
    parameter int WALK_VEL     = 2,
    parameter int H_JUMP_VEL   = 2,
    parameter int GRAVITY      = 1,
    parameter int MAX_FALL_VEL = 12,
    parameter int MAX_CHARGE   = 31,
    parameter int SPAWN_X      = 304
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic                        phys_tick,
    input  logic                        left_btn,
    input  logic                        right_btn,
    input  logic                        jump_btn,
    output logic signed [PHY_WIDTH:0]   pos_x,
    output logic signed [PHY_WIDTH:0]   pos_y,
    output logic signed [PHY_WIDTH:0]   vel_x,
    output logic signed [PHY_WIDTH:0]   vel_y,
    output logic [7:0]                  jump_cnt,
    output logic [1:0]                  face,
    output logic [2:0]                  state,
    output logic                        on_ground
);
    localparam int W = PHY_WIDTH + 2;
    typedef logic signed [W-1:0] wide_t;
    typedef logic signed [PHY_WIDTH:0] phy_t;

    localparam wide_t XMIN  = wide_t'(MAP_X_OFFSET + WALL_WIDTH);
    localparam wide_t XMAX  = wide_t'(MAP_X_OFFSET + MAP_WIDTH_X - WALL_WIDTH - CHAR_WIDTH_X);
    localparam wide_t YMIN  = wide_t'(MAP_Y_OFFSET + WALL_WIDTH);
    localparam wide_t FLOOR = wide_t'(MAP_Y_OFFSET + MAP_WIDTH_Y - WALL_WIDTH - CHAR_WIDTH_Y);
    localparam wide_t WALK  = wide_t'(WALK_VEL);
    localparam wide_t HJUMP = wide_t'(H_JUMP_VEL);
    localparam wide_t GRAV  = wide_t'(GRAVITY);
    localparam wide_t VMAX  = wide_t'(MAX_FALL_VEL);
    localparam wide_t ZERO  = wide_t'(0);
    localparam logic [7:0] CMAX = 8'(MAX_CHARGE);
    localparam phy_t SPAWN_XP = phy_t'(SPAWN_X);

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        LEFT           = 3'd1,
        RIGHT          = 3'd2,
        CHARGE         = 3'd3,
        JUMP           = 3'd4,
        COLLISION      = 3'd5,
        FALL_TO_GROUND = 3'd6
    } state_e;

    state_e     state_q, state_d;
    phy_t       pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    phy_t       vel_x_q, vel_x_d, vel_y_q, vel_y_d;
    logic [7:0] jump_cnt_q, jump_cnt_d;
    logic [1:0] face_q, face_d;
    logic       on_ground_q, on_ground_d;

    wide_t px, py, vx, vy, nx, ny, nvy;
    logic  hit_wall, hit_floor;

    function automatic wide_t clamp_x(input wide_t v);
        if (v < XMIN)      return XMIN;
        else if (v > XMAX) return XMAX;
        else               return v;
    endfunction

    function automatic phy_t narrow(input wide_t v);
        return v[PHY_WIDTH:0];
    endfunction

    always_comb begin
        px  = wide_t'(pos_x_q);
        py  = wide_t'(pos_y_q);
        vx  = wide_t'(vel_x_q);
        vy  = wide_t'(vel_y_q);
        nx  = px + vx;
        ny  = py + vy;
        nvy = (vy + GRAV > VMAX) ? VMAX : vy + GRAV;
        // Touching a wall counts as a hit so a sprite already flush against it still bounces.
        hit_wall  = (nx <= XMIN) || (nx >= XMAX);
        hit_floor = (ny >= FLOOR) && (vy > ZERO);

        state_d    = state_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        vel_x_d    = vel_x_q;
        vel_y_d    = vel_y_q;
        jump_cnt_d = jump_cnt_q;
        face_d     = face_q;

        case (state_q)
            IDLE, LEFT, RIGHT: begin
                if (jump_btn) begin
                    state_d    = CHARGE;
                    jump_cnt_d = 8'd1;
                    vel_x_d    = '0;
                end else if (left_btn && right_btn) begin
                    state_d = IDLE;
                    vel_x_d = '0;
                end else if (left_btn) begin
                    state_d = LEFT;
                    face_d  = 2'd1;
                    pos_x_d = narrow(clamp_x(px - WALK));
                    vel_x_d = narrow(-WALK);
                end else if (right_btn) begin
                    state_d = RIGHT;
                    face_d  = 2'd2;
                    pos_x_d = narrow(clamp_x(px + WALK));
                    vel_x_d = narrow(WALK);
                end else begin
                    state_d = IDLE;
                    vel_x_d = '0;
                end
            end
            CHARGE: begin
                if (left_btn && !right_btn)      face_d = 2'd1;
                else if (right_btn && !left_btn) face_d = 2'd2;
                if (jump_btn) begin
                    jump_cnt_d = (jump_cnt_q >= CMAX) ? CMAX : jump_cnt_q + 8'd1;
                end else begin
                    state_d = JUMP;
                    vel_y_d = narrow(-wide_t'(jump_cnt_q));
                    vel_x_d = (face_q == 2'd2) ? narrow(HJUMP) : narrow(-HJUMP);
                end
            end
            JUMP, COLLISION: begin
                if (hit_floor) begin
                    state_d = FALL_TO_GROUND;
                    pos_x_d = narrow(clamp_x(nx));
                    pos_y_d = narrow(FLOOR);
                    vel_x_d = '0;
                    vel_y_d = '0;
                end else begin
                    state_d = JUMP;
                    pos_x_d = narrow(nx);
                    pos_y_d = narrow(ny);
                    vel_y_d = narrow(nvy);
                    if (hit_wall) begin
                        state_d = COLLISION;
                        pos_x_d = narrow(clamp_x(nx));
                        vel_x_d = narrow(-vx);
                        face_d  = (face_q == 2'd1) ? 2'd2 : 2'd1;
                    end
                    if (ny < YMIN) begin
                        pos_y_d = narrow(YMIN);
                        vel_y_d = '0;
                    end
                end
            end
            FALL_TO_GROUND: begin
                state_d    = IDLE;
                vel_x_d    = '0;
                vel_y_d    = '0;
                jump_cnt_d = '0;
            end
            default: state_d = IDLE;
        endcase

        on_ground_d = !(state_d == JUMP || state_d == COLLISION);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            pos_x_q     <= SPAWN_XP;
            pos_y_q     <= narrow(FLOOR);
            vel_x_q     <= '0;
            vel_y_q     <= '0;
            jump_cnt_q  <= '0;
            face_q      <= 2'd2;
            on_ground_q <= 1'b1;
        end else if (phys_tick) begin
            state_q     <= state_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            vel_x_q     <= vel_x_d;
            vel_y_q     <= vel_y_d;
            jump_cnt_q  <= jump_cnt_d;
            face_q      <= face_d;
            on_ground_q <= on_ground_d;
        end
    end

    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
    assign vel_x     = vel_x_q;
    assign vel_y     = vel_y_q;
    assign jump_cnt  = jump_cnt_q;
    assign face      = face_q;
    assign state     = state_q;
    assign on_ground = on_ground_q;
endmodule

// File: tb/tb_char_motion_fsm.sv
// Randomised bench for char_motion_fsm: an integer-level motion model is compared every cycle,
// and directed scenarios pin both the DUT and the model to hand-worked positions.
module tb_char_motion_fsm;
    logic              clk = 1'b0;
    logic              sys_rst = 1'b1;
    logic              phys_tick = 1'b0;
    logic              left_btn = 1'b0, right_btn = 1'b0, jump_btn = 1'b0;
    logic signed [10:0] pos_x, pos_y, vel_x, vel_y;
    logic [7:0]        jump_cnt;
    logic [1:0]        face;
    logic [2:0]        state;
    logic              on_ground;

    int n_checks = 0;
    int n_errors = 0;

    char_motion_fsm dut (
        .sys_clk(clk), .sys_rst(sys_rst), .phys_tick(phys_tick),
        .left_btn(left_btn), .right_btn(right_btn), .jump_btn(jump_btn),
        .pos_x(pos_x), .pos_y(pos_y), .vel_x(vel_x), .vel_y(vel_y),
        .jump_cnt(jump_cnt), .face(face), .state(state), .on_ground(on_ground)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x, y, vx, vy, cnt, face, st;
    } mstate_t;

    mstate_t m;
    bit      model_valid = 1'b0;

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // Arena: x in [280,328], y in [60,108]; y grows downward.
    function automatic mstate_t step(input mstate_t s, input bit l, input bit r, input bit j);
        mstate_t n = s;
        int nx = s.x + s.vx;
        int ny = s.y + s.vy;
        if (s.st <= 2) begin
            if (j) begin n.st = 3; n.cnt = 1; n.vx = 0; end
            else if (l && r) begin n.st = 0; n.vx = 0; end
            else if (l) begin n.st = 1; n.face = 1; n.x = clampi(s.x - 2, 280, 328); n.vx = -2; end
            else if (r) begin n.st = 2; n.face = 2; n.x = clampi(s.x + 2, 280, 328); n.vx = 2; end
            else begin n.st = 0; n.vx = 0; end
        end else if (s.st == 3) begin
            if (l && !r) n.face = 1;
            if (r && !l) n.face = 2;
            if (j) n.cnt = (s.cnt + 1 > 31) ? 31 : s.cnt + 1;
            else begin n.st = 4; n.vy = -s.cnt; n.vx = (s.face == 2) ? 2 : -2; end
        end else if (s.st == 4 || s.st == 5) begin
            if (ny >= 108 && s.vy > 0) begin
                n.st = 6; n.x = clampi(nx, 280, 328); n.y = 108; n.vx = 0; n.vy = 0;
            end else begin
                n.st = 4; n.x = nx; n.y = ny;
                n.vy = (s.vy + 1 > 12) ? 12 : s.vy + 1;
                if (nx <= 280 || nx >= 328) begin
                    n.st = 5; n.x = clampi(nx, 280, 328); n.vx = -s.vx; n.face = 3 - s.face;
                end
                if (ny < 60) begin n.y = 60; n.vy = 0; end
            end
        end else begin
            n.st = 0; n.vx = 0; n.vy = 0; n.cnt = 0;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (sys_rst) begin
            m <= '{x: 304, y: 108, vx: 0, vy: 0, cnt: 0, face: 2, st: 0};
            model_valid <= 1'b1;
        end else if (phys_tick) begin
            m <= step(m, left_btn, right_btn, jump_btn);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            chk("pos_x", int'(pos_x), m.x);
            chk("pos_y", int'(pos_y), m.y);
            chk("vel_x", int'(vel_x), m.vx);
            chk("vel_y", int'(vel_y), m.vy);
            chk("jump_cnt", int'(jump_cnt), m.cnt);
            chk("face", int'(face), m.face);
            chk("state", int'(state), m.st);
            chk("on_ground", int'(on_ground), (m.st == 4 || m.st == 5) ? 0 : 1);
        end
    end

    task automatic cyc(input bit t, input bit l, input bit r, input bit j);
        phys_tick = t; left_btn = l; right_btn = r; jump_btn = j;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        sys_rst = 1'b0;
    endtask

    task automatic ticks(input int n, input bit l, input bit r, input bit j);
        for (int i = 0; i < n; i++) cyc(1'b1, l, r, j);
    endtask

    initial begin
        int  hold;
        bit  rl, rr, rj, saw_coll;

        // Reset and idle.
        do_reset();
        chk("rst_state", int'(state), 0);
        ticks(3, 0, 0, 0);
        chk("idle_x", int'(pos_x), 304);
        chk("idle_y", int'(pos_y), 108);
        chk("idle_state", int'(state), 0);
        chk("idle_face", int'(face), 2);
        chk("idle_on_ground", int'(on_ground), 1);

        // Walk right into the right wall.
        ticks(5, 0, 1, 0);
        chk("walk_x", int'(pos_x), 314);
        chk("walk_state", int'(state), 2);
        saw_coll = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b0);
            if (state == 3'd5) saw_coll = 1'b1;
        end
        chk("walk_x_clamped", int'(pos_x), 328);
        chk("walk_no_collision", int'(saw_coll), 0);

        // Short jump from spawn.
        do_reset();
        ticks(5, 0, 0, 1);
        ticks(1, 0, 0, 0);
        chk("launch_state", int'(state), 4);
        chk("launch_vx", int'(vel_x), 2);
        chk("launch_vy", int'(vel_y), -5);
        chk("launch_cnt", int'(jump_cnt), 5);
        ticks(11, 0, 0, 0);
        chk("land_y", int'(pos_y), 108);
        chk("land_x", int'(pos_x), 326);
        chk("land_state", int'(state), 6);
        chk("model_land_x", m.x, 326);
        ticks(1, 0, 0, 0);
        chk("after_land_state", int'(state), 0);
        chk("after_land_cnt", int'(jump_cnt), 0);

        // Wall bounce from x=320.
        do_reset();
        ticks(8, 0, 1, 0);
        chk("pre_bounce_x", int'(pos_x), 320);
        ticks(5, 0, 0, 1);
        ticks(1, 0, 0, 0);
        ticks(4, 0, 0, 0);
        chk("bounce_x", int'(pos_x), 328);
        chk("bounce_state", int'(state), 5);
        chk("bounce_vx", int'(vel_x), -2);
        chk("bounce_face", int'(face), 1);
        chk("model_bounce_state", m.st, 5);
        ticks(1, 0, 0, 0);
        chk("post_bounce_state", int'(state), 4);
        chk("post_bounce_x", int'(pos_x), 326);
        ticks(20, 0, 0, 0);

        // Full charge hits the ceiling.
        do_reset();
        ticks(40, 0, 0, 1);
        chk("max_charge", int'(jump_cnt), 31);
        ticks(1, 0, 0, 0);
        chk("max_vy", int'(vel_y), -31);
        ticks(1, 0, 0, 0);
        chk("rise_y", int'(pos_y), 77);
        ticks(1, 0, 0, 0);
        chk("ceiling_y", int'(pos_y), 60);
        chk("ceiling_vy", int'(vel_y), 0);
        chk("ceiling_state", int'(state), 4);

        // Reset mid-jump without a physics tick.
        sys_rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        sys_rst = 1'b0;
        chk("midrst_x", int'(pos_x), 304);
        chk("midrst_y", int'(pos_y), 108);
        chk("midrst_vy", int'(vel_y), 0);
        chk("midrst_cnt", int'(jump_cnt), 0);
        chk("midrst_state", int'(state), 0);
        chk("midrst_on_ground", int'(on_ground), 1);

        // Buttons without ticks do nothing.
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("notick_x", int'(pos_x), 304);
        chk("notick_state", int'(state), 0);

        // Random play.
        hold = 0;
        rl = 0; rr = 0; rj = 0;
        for (int i = 0; i < 5000; i++) begin
            if (hold == 0) begin
                hold = $urandom_range(1, 40);
                rl = ($urandom_range(0, 2) == 0);
                rr = ($urandom_range(0, 2) == 0);
                rj = ($urandom_range(0, 3) == 0);
            end
            hold--;
            sys_rst = ($urandom_range(0, 999) == 0);
            cyc($urandom_range(0, 3) != 0, rl, rr, rj);
        end
        sys_rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
